// File: rtl/dpram_wconv_dbuf_pkg.sv
// Shared definitions for the double-buffered width-converting frame RAM:
// ceil-log2 helper used to derive address widths, and the swap FSM states.
package dpram_wconv_dbuf_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/dpram_wconv_dbuf_lane.sv
// One narrow lane of the frame RAM: simple dual-port, single clock,
// registered read that holds its value when no read is requested.
module dpram_lane #(
    parameter int DATA_W = 8,
    parameter int AW     = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**AW];
    logic [DATA_W-1:0] r_rdata_p1;

    // Write port: storage itself is never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: one-cycle registered read, cleared by reset, held without a read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata_p1 <= '0;
        end else if (i_re) begin
            r_rdata_p1 <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/dpram_wconv_dbuf.sv
// Double-buffered frame RAM: narrow writes into the back bank, whole-row
// reads from the front bank, bank swap on a req/ack handshake that only
// completes at a scan frame boundary.
// Optional feature: define DPRAM_WCONV_CLEAR_EN to zero the new back bank
// after every swap (wr_busy is high while the clear engine runs).
module dpram_wconv_dbuf
    import dpram_wconv_dbuf_pkg::*;
#(
    parameter int NARROW_W = 8,
    parameter int RATIO    = 8,
    parameter int RD_AW    = 7,
    localparam int LW      = clog2(RATIO),
    localparam int WR_AW   = RD_AW + LW,
    localparam int WIDE_W  = NARROW_W * RATIO
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr_en,
    input  logic [WR_AW-1:0]    i_wr_addr,
    input  logic [NARROW_W-1:0] i_wr_data,
    output logic                o_wr_busy,
    input  logic                i_rd_en,
    input  logic [RD_AW-1:0]    i_rd_addr,
    output logic [WIDE_W-1:0]   o_rd_data,
    output logic                o_rd_valid,
    input  logic                i_swap_req,
    input  logic                i_frame_end,
    output logic                o_swap_ack,
    output logic                o_front_sel
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_swap;
    logic                r_front_sel;
    logic                r_swap_ack;
    logic                r_rd_vld_p1;
    logic                w_wr_busy;
    logic                w_clr_we;
    logic                w_clr_last;
    logic                w_clr_pend;
    logic [RD_AW-1:0]    w_clr_row;
    logic                w_wr_ok;
    logic [LW-1:0]       w_wr_lane;
    logic [RD_AW-1:0]    w_wr_row;
    logic [RD_AW:0]      w_lane_waddr;
    logic [NARROW_W-1:0] w_lane_wdata;
    logic [RD_AW:0]      w_lane_raddr;
    logic [WIDE_W-1:0]   w_rd_data;

`ifdef DPRAM_WCONV_CLEAR_EN
    logic [RD_AW-1:0] r_clr_row;
    logic             r_clr_req;

    // Clear row counter: sweeps every row of the back bank once per CLEAR visit.
    always_ff @(posedge i_clk) begin
        if (i_reset || r_state != ST_CLEAR) begin
            r_clr_row <= '0;
        end else begin
            r_clr_row <= r_clr_row + 1'b1;
        end
    end

    // Remember a swap request that arrives while clearing, so it becomes pending on exit.
    always_ff @(posedge i_clk) begin
        if (i_reset || r_state != ST_CLEAR) begin
            r_clr_req <= 1'b0;
        end else if (i_swap_req) begin
            r_clr_req <= 1'b1;
        end
    end

    // The clear write is suppressed during reset so an aborted clear stops cleanly.
    assign w_clr_we   = (r_state == ST_CLEAR) && !i_reset;
    assign w_wr_busy  = (r_state == ST_CLEAR);
    assign w_clr_row  = r_clr_row;
    assign w_clr_last = &r_clr_row;
    assign w_clr_pend = r_clr_req | i_swap_req;
`else
    assign w_clr_we   = 1'b0;
    assign w_wr_busy  = 1'b0;
    assign w_clr_row  = '0;
    assign w_clr_last = 1'b1;
    assign w_clr_pend = 1'b0;
`endif

    // Swap FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Swap FSM next state: a swap needs a request and a frame boundary, together or in order.
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_swap_req) begin
                    if (i_frame_end) begin
                        w_swap = 1'b1;
                    end else begin
                        w_state_nxt = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (i_frame_end) begin
                    w_swap = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt = w_clr_pend ? ST_PEND : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_swap) begin
`ifdef DPRAM_WCONV_CLEAR_EN
            w_state_nxt = ST_CLEAR;
`else
            w_state_nxt = ST_IDLE;
`endif
        end
    end

    // Bank select toggle and single-cycle acknowledge on each swap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_front_sel <= 1'b0;
            r_swap_ack  <= 1'b0;
        end else begin
            r_swap_ack <= w_swap;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    // Read valid follows the read strobe by the one-cycle RAM latency.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_vld_p1 <= 1'b0;
        end else begin
            r_rd_vld_p1 <= i_rd_en;
        end
    end

    // Lane-write decode: the clear engine owns all lanes; otherwise one lane per write.
    assign w_wr_lane    = i_wr_addr[LW-1:0];
    assign w_wr_row     = i_wr_addr[WR_AW-1:LW];
    assign w_wr_ok      = i_wr_en && !w_wr_busy;
    assign w_lane_waddr = w_clr_we ? {~r_front_sel, w_clr_row} : {~r_front_sel, w_wr_row};
    assign w_lane_wdata = w_clr_we ? '0 : i_wr_data;
    assign w_lane_raddr = {r_front_sel, i_rd_addr};

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        logic w_we;
        assign w_we = w_clr_we | (w_wr_ok && (w_wr_lane == LW'(g)));

        dpram_lane #(
            .DATA_W (NARROW_W),
            .AW     (RD_AW + 1)
        ) u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_we    (w_we),
            .i_waddr (w_lane_waddr),
            .i_wdata (w_lane_wdata),
            .i_re    (i_rd_en),
            .i_raddr (w_lane_raddr),
            .o_rdata (w_rd_data[g*NARROW_W +: NARROW_W])
        );
    end

    assign o_rd_data   = w_rd_data;
    assign o_rd_valid  = r_rd_vld_p1;
    assign o_swap_ack  = r_swap_ack;
    assign o_front_sel = r_front_sel;
    assign o_wr_busy   = w_wr_busy;

endmodule

// File: tb/tb_dpram_wconv_dbuf.sv
// Testbench for dpram_wconv_dbuf with a row/bank-level reference model.
module tb_dpram_wconv_dbuf;

    localparam int NW   = 8;
    localparam int R    = 8;
    localparam int AW   = 7;
    localparam int WW   = NW * R;
    localparam int ROWS = 2 ** AW;
    localparam int WAW  = AW + 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           wr_en;
    logic [WAW-1:0] wr_addr;
    logic [NW-1:0]  wr_data;
    logic           wr_busy;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [WW-1:0]  rd_data;
    logic           rd_valid;
    logic           swap_req;
    logic           frame_end;
    logic           swap_ack;
    logic           front_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: two banks of whole rows, per-lane "written" flags
    logic [WW-1:0] m_bank  [2][ROWS];
    logic [R-1:0]  m_known [2][ROWS];
    bit            m_front;
    bit            m_pend;
    bit            m_ack;
    int            m_clr_left;
    bit            m_clr_req;
    logic [WW-1:0] m_rd;
    logic [WW-1:0] m_mask;
    bit            m_rdv;

    dpram_wconv_dbuf dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_busy   (wr_busy),
        .i_rd_en     (rd_en),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .i_swap_req  (swap_req),
        .i_frame_end (frame_end),
        .o_swap_ack  (swap_ack),
        .o_front_sel (front_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [WW-1:0] lane_mask(input logic [R-1:0] k);
        logic [WW-1:0] m;
        m = '0;
        for (int l = 0; l < R; l++) m[l*NW +: NW] = {NW{k[l]}};
        return m;
    endfunction

    function automatic bit clear_enabled();
`ifdef DPRAM_WCONV_CLEAR_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        bit clr;
        int fb;
        int bb;
        int row;
        int lane;
        if (reset) begin
            m_front = 0; m_pend = 0; m_ack = 0; m_clr_left = 0; m_clr_req = 0;
            m_rd = '0; m_mask = '1; m_rdv = 0;
            return;
        end
        fb  = m_front ? 1 : 0;
        bb  = 1 - fb;
        clr = (m_clr_left > 0);
        if (wr_en && !clr) begin
            row  = int'(wr_addr[WAW-1:3]);
            lane = int'(wr_addr[2:0]);
            m_bank[bb][row][lane*NW +: NW] = wr_data;
            m_known[bb][row][lane] = 1'b1;
        end
        if (clr) begin
            row = ROWS - m_clr_left;
            m_bank[bb][row]  = '0;
            m_known[bb][row] = '1;
            if (swap_req) m_clr_req = 1;
            m_clr_left--;
            if (m_clr_left == 0) begin
                m_pend    = m_clr_req;
                m_clr_req = 0;
            end
        end
        if (rd_en) begin
            m_rd   = m_bank[fb][rd_addr];
            m_mask = lane_mask(m_known[fb][rd_addr]);
            m_rdv  = 1;
        end else begin
            m_rdv = 0;
        end
        m_ack = 0;
        if (!clr && frame_end && (m_pend || swap_req)) begin
            m_front = !m_front;
            m_pend  = 0;
            m_ack   = 1;
            if (clear_enabled()) m_clr_left = ROWS;
        end else if (!clr && swap_req) begin
            m_pend = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        wr_en = 0; rd_en = 0; swap_req = 0; frame_end = 0; reset = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && wr_busy; i++) tick();
        n_checks++;
        if (wr_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: wr_busy=%0b still set after 400 cycles, required 0", wr_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1; tick();
        reset = 1; tick();
        n_checks++;
        if (front_sel !== 1'b0 || swap_ack !== 1'b0 || rd_valid !== 1'b0 || wr_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: front=%0b ack=%0b vld=%0b busy=%0b, required all 0",
                     front_sel, swap_ack, rd_valid, wr_busy);
        end
        n_checks++;
        if (rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h required 0", rd_data);
        end
    endtask

    task automatic test_basic_swap_read();
        for (int a = 0; a < 8; a++) begin
            wr_en = 1; wr_addr = WAW'(a); wr_data = NW'(8'h10 + a);
            tick();
        end
        swap_req = 1; frame_end = 1; tick();
        n_checks++;
        if (front_sel !== 1'b1 || swap_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_swap: front=%0b ack=%0b, required 1 1", front_sel, swap_ack);
        end
        wait_idle();
        rd_en = 1; rd_addr = '0; tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h1716151413121110) begin
            n_fail++;
            $display("FAIL basic_read: vld=%0b data=%h, required 1 1716151413121110", rd_valid, rd_data);
        end
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 64'h1716151413121110) begin
            n_fail++;
            $display("FAIL basic_hold: vld=%0b data=%h, required 0 1716151413121110", rd_valid, rd_data);
        end
    endtask

    task automatic test_delayed_frame_end();
        bit f0;
        wait_idle();
        f0 = m_front;
        swap_req = 1; tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (front_sel !== f0 || swap_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL pend_wait[%0d]: front=%0b ack=%0b, required %0b 0", i, front_sel, swap_ack, f0);
            end
            tick();
        end
        n_checks++;
        if (front_sel !== f0 || swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_last: front=%0b ack=%0b, required %0b 0", front_sel, swap_ack, f0);
        end
        frame_end = 1; tick();
        n_checks++;
        if (front_sel !== !f0 || swap_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_swap: front=%0b ack=%0b, required %0b 1", front_sel, swap_ack, !f0);
        end
        tick();
        n_checks++;
        if (swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_width: ack=%0b one cycle after swap, required 0", swap_ack);
        end
    endtask

    task automatic test_write_in_swap_cycle();
        bit f0;
        wait_idle();
        f0 = m_front;
        for (int l = 0; l < 7; l++) begin
            wr_en = 1; wr_addr = WAW'(3*8 + l); wr_data = NW'($urandom); tick();
        end
        wr_en = 1; wr_addr = WAW'(3*8 + 7); wr_data = NW'($urandom);
        swap_req = 1; frame_end = 1; tick();
        n_checks++;
        if (front_sel !== !f0) begin
            n_fail++;
            $display("FAIL swapcyc_front: got %0b required %0b", front_sel, !f0);
        end
        wait_idle();
        rd_en = 1; rd_addr = 7'd3; tick();
        n_checks++;
        if (rd_valid !== 1'b1 || ((rd_data ^ m_rd) & m_mask) !== '0 || m_mask !== '1) begin
            n_fail++;
            $display("FAIL swapcyc_read1: vld=%0b data=%h, required 1 %h", rd_valid, rd_data, m_rd);
        end
        for (int s = 0; s < 2; s++) begin
            swap_req = 1; frame_end = 1; tick();
            wait_idle();
        end
        rd_en = 1; rd_addr = 7'd3; tick();
        n_checks++;
        if (rd_valid !== 1'b1 || ((rd_data ^ m_rd) & m_mask) !== '0) begin
            n_fail++;
            $display("FAIL swapcyc_read2: vld=%0b data=%h, required 1 %h", rd_valid, rd_data, m_rd);
        end
    endtask

    task automatic test_repeated_req();
        bit f0;
        int acks;
        wait_idle();
        f0 = m_front;
        acks = 0;
        swap_req = 1; tick(); acks += int'(swap_ack);
        for (int i = 0; i < 3; i++) begin
            swap_req = 1; tick(); acks += int'(swap_ack);
        end
        frame_end = 1; tick(); acks += int'(swap_ack);
        for (int i = 0; i < 3; i++) begin
            tick(); acks += int'(swap_ack);
        end
        n_checks++;
        if (acks != 1 || front_sel !== !f0) begin
            n_fail++;
            $display("FAIL repeated_req: acks=%0d front=%0b, required 1 %0b", acks, front_sel, !f0);
        end
        frame_end = 1; tick();
        n_checks++;
        if (swap_ack !== 1'b0 || front_sel !== !f0) begin
            n_fail++;
            $display("FAIL no_queue: ack=%0b front=%0b, required 0 %0b", swap_ack, front_sel, !f0);
        end
    endtask

    task automatic test_reset_in_pend();
        wait_idle();
        if (!m_front) begin
            swap_req = 1; frame_end = 1; tick();
            wait_idle();
        end
        n_checks++;
        if (front_sel !== 1'b1) begin
            n_fail++;
            $display("FAIL rstpend_setup: front=%0b required 1", front_sel);
        end
        swap_req = 1; tick();
        reset = 1; tick();
        n_checks++;
        if (front_sel !== 1'b0 || swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rstpend_reset: front=%0b ack=%0b, required 0 0", front_sel, swap_ack);
        end
        frame_end = 1; tick();
        n_checks++;
        if (front_sel !== 1'b0 || swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rstpend_no_swap: front=%0b ack=%0b, required 0 0", front_sel, swap_ack);
        end
        swap_req = 1; frame_end = 1; tick();
        for (int i = 0; i < 3; i++) tick();
        reset = 1; tick();
        n_checks++;
        if (front_sel !== 1'b0 || wr_busy !== 1'b0 || swap_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_midswap: front=%0b busy=%0b ack=%0b, required 0 0 0", front_sel, wr_busy, swap_ack);
        end
    endtask

`ifdef DPRAM_WCONV_CLEAR_EN
    task automatic test_clear();
        int nbusy;
        wait_idle();
        swap_req = 1; frame_end = 1; tick();
        n_checks++;
        if (wr_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_start: busy=%0b required 1", wr_busy);
        end
        nbusy = 0;
        while (wr_busy && nbusy < 300) begin
            nbusy++;
            if (nbusy == 140) begin
                wr_en = 1; wr_addr = WAW'(5*8 + 2); wr_data = 8'hAB;
            end else if (nbusy == 10) begin
                wr_en = 1; wr_addr = WAW'(5*8 + 2); wr_data = 8'hAB;
            end
            tick();
        end
        n_checks++;
        if (nbusy != ROWS) begin
            n_fail++;
            $display("FAIL clear_len: busy cycles=%0d required %0d", nbusy, ROWS);
        end
        swap_req = 1; frame_end = 1; tick();
        wait_idle();
        rd_en = 1; rd_addr = 7'd5; tick();
        n_checks++;
        if (rd_data !== '0) begin
            n_fail++;
            $display("FAIL clear_row5: data=%h required 0", rd_data);
        end
        for (int r = 0; r < ROWS; r += 17) begin
            rd_en = 1; rd_addr = AW'(r); tick();
            n_checks++;
            if (rd_data !== '0) begin
                n_fail++;
                $display("FAIL clear_row%0d: data=%h required 0", r, rd_data);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = WAW'({$urandom_range(0, 7), 3'($urandom)});
            wr_data   = NW'($urandom);
            rd_en     = ($urandom_range(0, 1) == 1);
            rd_addr   = AW'($urandom_range(0, 7));
            swap_req  = ($urandom_range(0, 15) == 0);
            frame_end = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++;
            if (front_sel !== m_front || swap_ack !== m_ack || rd_valid !== m_rdv ||
                wr_busy !== (m_clr_left > 0)) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: front=%0b ack=%0b vld=%0b busy=%0b, required %0b %0b %0b %0b",
                         c, front_sel, swap_ack, rd_valid, wr_busy, m_front, m_ack, m_rdv, m_clr_left > 0);
            end
            n_checks++;
            if (((rd_data ^ m_rd) & m_mask) !== '0) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got %h required %h (mask %h)", c, rd_data, m_rd, m_mask);
            end
        end
    endtask

    initial begin
        reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
        rd_en = 0; rd_addr = '0; swap_req = 0; frame_end = 0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) begin
                m_bank[b][r] = '0;
                m_known[b][r] = '0;
            end
        m_front = 0; m_pend = 0; m_ack = 0; m_clr_left = 0; m_clr_req = 0;
        m_rd = '0; m_mask = '1; m_rdv = 0;
        #2;
        test_reset();
        test_basic_swap_read();
        test_delayed_frame_end();
        test_write_in_swap_cycle();
        test_repeated_req();
        test_reset_in_pend();
`ifdef DPRAM_WCONV_CLEAR_EN
        test_clear();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
